// File: rtl/bin_to_bcd_stream_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
package bin_to_bcd_stream_pkg;

  // Width of one packed BCD digit.
  localparam int DIGIT_W = 4;

  // Controller state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit position of the least significant bit of digit i.
  function automatic int digit_lsb(input int i);
    return i * DIGIT_W;
  endfunction

endpackage

// File: rtl/bin_to_bcd_stream_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the next
// left shift carries into the neighbouring digit.
module bin_to_bcd_stream_digit_adj
  import bin_to_bcd_stream_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  // Largest result is 9+3 = 4'hC, so 4 bits never overflow.
  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin_to_bcd_stream.sv
// Sequential binary-to-BCD converter, one input bit per cycle, with
// valid/ready on both sides, optional two's-complement input, overflow flag
// and leading-zero blank mask.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// CONV  | shifting one magnitude bit into the BCD register per cycle
// DONE  | result presented on out_valid until out_ready
module bin_to_bcd_stream
  import bin_to_bcd_stream_pkg::*;
#(
  parameter int BIN_W     = 16,
  parameter int DIGITS    = 5,
  parameter int SIGNED_IN = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      neg,
  output logic                      ovf,
  output logic [DIGITS-1:0]         blank
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  logic [1:0]       state;
  logic [BIN_W-1:0] mag;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_adj;

  // Per-digit add-3 correction applied to the registered BCD value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin_to_bcd_stream_digit_adj u_adj (
      .digit_in  (bcd[digit_lsb(g) +: DIGIT_W]),
      .digit_out (bcd_adj[digit_lsb(g) +: DIGIT_W])
    );
  end

  // Leading-zero mask: digit i is blank when it and every digit above it is 0.
  for (genvar i = 0; i < DIGITS; i++) begin : g_blank
    if (i == 0) begin : g_lsd
      assign blank[i] = 1'b0;
    end else begin : g_upper
      assign blank[i] = (bcd[BCD_W-1:digit_lsb(i)] == '0);
    end
  end

  assign in_ready = (state == ST_IDLE);

  // Accept, shift/convert and output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      bcd       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      mag       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Negating the most negative value wraps to 2^(BIN_W-1), which
            // is exactly its magnitude when read as unsigned.
            if ((SIGNED_IN != 0) && bin_in[BIN_W-1]) begin
              mag <= -bin_in;
              neg <= 1'b1;
            end else begin
              mag <= bin_in;
              neg <= 1'b0;
            end
            bcd   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          bcd <= {bcd_adj[BCD_W-2:0], mag[BIN_W-1]};
          mag <= {mag[BIN_W-2:0], 1'b0};
          // Any bit pushed out of the top digit means the value does not fit.
          ovf <= ovf | bcd_adj[BCD_W-1];
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_stream.sv
// Bench for bin_to_bcd_stream: three instances (default, signed input,
// four digits) share one stimulus stream and are checked in lockstep.
module tb_bin_to_bcd_stream;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [15:0] bin_in;
  logic out_ready;

  logic ir_d, ov_d, neg_d, ovf_d;
  logic [19:0] bcd_d;
  logic [4:0]  blank_d;
  logic ir_s, ov_s, neg_s, ovf_s;
  logic [19:0] bcd_s;
  logic [4:0]  blank_s;
  logic ir_q, ov_q, neg_q, ovf_q;
  logic [15:0] bcd_q;
  logic [3:0]  blank_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_stream u_def (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_d),
    .bin_in(bin_in), .out_valid(ov_d), .out_ready(out_ready),
    .bcd(bcd_d), .neg(neg_d), .ovf(ovf_d), .blank(blank_d));

  bin_to_bcd_stream #(.BIN_W(16), .DIGITS(5), .SIGNED_IN(1)) u_sgn (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_s),
    .bin_in(bin_in), .out_valid(ov_s), .out_ready(out_ready),
    .bcd(bcd_s), .neg(neg_s), .ovf(ovf_s), .blank(blank_s));

  bin_to_bcd_stream #(.BIN_W(16), .DIGITS(4), .SIGNED_IN(0)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_q),
    .bin_in(bin_in), .out_valid(ov_q), .out_ready(out_ready),
    .bcd(bcd_q), .neg(neg_q), .ovf(ovf_q), .blank(blank_q));

  typedef struct {
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
    logic [4:0]  blank;
  } res_t;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] d_bcd;
    logic [4:0]  d_blank;
    logic [19:0] s_bcd;
    logic        s_neg;
    logic [15:0] q_bcd;
    logic        q_ovf;
  } vec_t;

  // Reference: decimal digits by plain integer arithmetic.
  function automatic res_t model(input logic [15:0] v, input bit sgn, input int digits);
    res_t r;
    int m, lim, low, t, p;
    m = int'(v);
    r.neg = 1'b0;
    if (sgn && v[15]) begin
      m = 65536 - int'(v);
      r.neg = 1'b1;
    end
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    r.ovf = (m >= lim);
    low = m % lim;
    r.bcd = '0;
    t = low;
    for (int i = 0; i < digits; i++) begin
      r.bcd[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    r.blank = '0;
    p = 10;
    for (int i = 1; i < digits; i++) begin
      r.blank[i] = ((low / p) == 0);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present v until accepted (bounded), then check 16-edge latency.
  task automatic run(input logic [15:0] v);
    int n;
    bit acc;
    in_valid = 1'b1;
    bin_in   = v;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      if (ir_d) acc = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
    n = 0;
    while (!ov_d && n < 100) begin
      tick();
      n++;
    end
    chk("latency", n, 16);
    chk("lockstep_s", 32'(ov_s), 32'd1);
    chk("lockstep_q", 32'(ov_q), 32'd1);
  endtask

  // Hold back-pressure k cycles with ignored in_valid pulses, then hand off.
  task automatic finish(input int k);
    logic [19:0] sd, ss;
    logic [15:0] sq;
    logic        sn, so;
    sd = bcd_d; ss = bcd_s; sq = bcd_q; sn = neg_s; so = ovf_q;
    out_ready = 1'b0;
    for (int i = 0; i < k; i++) begin
      in_valid = 1'b1;
      bin_in   = 16'($urandom);
      tick();
      in_valid = 1'b0;
      chk("bp_valid", 32'(ov_d), 32'd1);
      chk("bp_in_ready", 32'(ir_d), 32'd0);
      chk("bp_bcd_d", 32'(bcd_d), 32'(sd));
      chk("bp_bcd_s", 32'(bcd_s), 32'(ss));
      chk("bp_bcd_q", 32'(bcd_q), 32'(sq));
      chk("bp_neg_s", 32'(neg_s), 32'(sn));
      chk("bp_ovf_q", 32'(ovf_q), 32'(so));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_valid", 32'(ov_d), 32'd0);
    chk("handoff_ready", 32'(ir_d), 32'd1);
  endtask

  task automatic check_model(input logic [15:0] v);
    res_t rd, rs, rq;
    rd = model(v, 1'b0, 5);
    rs = model(v, 1'b1, 5);
    rq = model(v, 1'b0, 4);
    chk("m_bcd_d", 32'(bcd_d), 32'(rd.bcd));
    chk("m_blank_d", 32'(blank_d), 32'(rd.blank));
    chk("m_ovf_d", 32'(ovf_d), 32'(rd.ovf));
    chk("m_neg_d", 32'(neg_d), 32'd0);
    chk("m_bcd_s", 32'(bcd_s), 32'(rs.bcd));
    chk("m_neg_s", 32'(neg_s), 32'(rs.neg));
    chk("m_blank_s", 32'(blank_s), 32'(rs.blank));
    chk("m_bcd_q", 32'(bcd_q), 32'(rq.bcd[15:0]));
    chk("m_ovf_q", 32'(ovf_q), 32'(rq.ovf));
    chk("m_blank_q", 32'(blank_q), 32'(rq.blank[3:0]));
  endtask

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r1, r2;
    logic ir17, ov17;
    logic [19:0] bcd34;

    vecs[0] = '{16'h0000, 20'h00000, 5'b11110, 20'h00000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'hFFFF, 20'h65535, 5'b00000, 20'h00001, 1'b1, 16'h5535, 1'b1};
    vecs[2] = '{16'h8000, 20'h32768, 5'b00000, 20'h32768, 1'b1, 16'h2768, 1'b1};
    vecs[3] = '{16'd9999, 20'h09999, 5'b10000, 20'h09999, 1'b0, 16'h9999, 1'b0};
    vecs[4] = '{16'd10000, 20'h10000, 5'b00000, 20'h10000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'd42, 20'h00042, 5'b11100, 20'h00042, 1'b0, 16'h0042, 1'b0};
    vecs[6] = '{16'd1234, 20'h01234, 5'b10000, 20'h01234, 1'b0, 16'h1234, 1'b0};

    reset = 1'b1; in_valid = 1'b0; bin_in = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_valid", 32'(ov_d | ov_s | ov_q), 32'd0);
    chk("rst_ready", 32'({ir_d, ir_s, ir_q}), 32'h7);
    chk("rst_bcd", 32'(bcd_d | bcd_s | 20'(bcd_q)), 32'd0);
    chk("rst_flags", 32'({neg_d, neg_s, neg_q, ovf_d, ovf_s, ovf_q}), 32'd0);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      run(vecs[i].bin);
      chk("t_bcd_d", 32'(bcd_d), 32'(vecs[i].d_bcd));
      chk("t_blank_d", 32'(blank_d), 32'(vecs[i].d_blank));
      chk("t_ovf_d", 32'(ovf_d), 32'd0);
      chk("t_bcd_s", 32'(bcd_s), 32'(vecs[i].s_bcd));
      chk("t_neg_s", 32'(neg_s), 32'(vecs[i].s_neg));
      chk("t_bcd_q", 32'(bcd_q), 32'(vecs[i].q_bcd));
      chk("t_ovf_q", 32'(ovf_q), 32'(vecs[i].q_ovf));
      check_model(vecs[i].bin);
      finish(i == 1 ? 5 : (i % 3));
    end

    // Reset in the middle of a conversion.
    run(16'd1234);
    finish(0);
    in_valid = 1'b1; bin_in = 16'd1234;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", 32'(ov_d), 32'd0);
    chk("midrst_bcd", 32'(bcd_d), 32'd0);
    chk("midrst_ready", 32'(ir_d), 32'd1);
    run(16'd567);
    chk("after_rst_bcd", 32'(bcd_d), 32'h00567);
    check_model(16'd567);
    finish(1);

    // Back-to-back throughput with out_ready held high.
    out_ready = 1'b1; in_valid = 1'b1; bin_in = 16'hFFFF;
    tick();  // accepted at this edge (block is idle)
    r1 = -1; r2 = -1; ir17 = 1'b0; ov17 = 1'b1; bcd34 = '0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 18) in_valid = 1'b0;
      if (n == 17) begin ir17 = ir_d; ov17 = ov_d; end
      if (ov_d && r1 < 0) r1 = n;
      else if (ov_d && r1 >= 0 && n > r1 + 1 && r2 < 0) begin r2 = n; bcd34 = bcd_d; end
    end
    out_ready = 1'b0;
    chk("b2b_first", r1, 16);
    chk("b2b_ready_after", 32'(ir17), 32'd1);
    chk("b2b_valid_drop", 32'(ov17), 32'd0);
    chk("b2b_second", r2, 34);
    chk("b2b_bcd", 32'(bcd34), 32'h65535);

    // Randomized values with random back-pressure.
    for (int i = 0; i < 30; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (i % 5 == 0) v = 16'($urandom_range(0, 20000));
      run(v);
      check_model(v);
      finish(int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
